// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - fetch/decode/execute/memory/writeback sequencer with sticky halt and instret counter
// Optional per-state memory timeout enabled by defining CORE_SEQ_TIMEOUT_EN.
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        ifu_req_valid_o,
    input  logic        ifu_req_ready_i,
    input  logic        ifu_resp_valid_i,
    input  logic        ifu_resp_err_i,
    output logic        inst_latch_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic        is_ebreak_i,
    input  logic        is_illegal_i,
    input  logic        rd_wen_i,
    output logic        lsu_req_valid_o,
    input  logic        lsu_req_ready_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    output logic        rf_wen_o,
    output logic        pc_wen_o,
    output logic        halt_o,
    output logic [1:0]  halt_code_o,
    output logic [63:0] instret_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        EXEC       = 3'd3,
        MEM_REQ    = 3'd4,
        MEM_WAIT   = 3'd5,
        WB         = 3'd6,
        HALT       = 3'd7
    } state_e;

    state_e      state_q;
    logic [1:0]  halt_code_q;
    logic [63:0] instret_q;
    logic        exit_now;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end

    // Exit condition of the current state; a met exit always beats a timeout.
    always_comb begin
        exit_now = 1'b1;
        case (state_q)
            FETCH_REQ:  exit_now = ifu_req_ready_i;
            FETCH_WAIT: exit_now = ifu_resp_valid_i;
            MEM_REQ:    exit_now = lsu_req_ready_i;
            MEM_WAIT:   exit_now = lsu_resp_valid_i;
            HALT:       exit_now = 1'b0;
            default:    exit_now = 1'b1;
        endcase
    end

`ifdef CORE_SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic        in_wait;

    assign in_wait     = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                         (state_q == MEM_REQ)   || (state_q == MEM_WAIT);
    assign timeout_hit = in_wait && !exit_now &&
                         (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (exit_now || timeout_hit) begin
            wait_cnt_q <= '0;
        end else if (in_wait) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FETCH_REQ;
            halt_code_q <= 2'd0;
            instret_q   <= 64'd0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (ifu_req_ready_i) begin
                        state_q <= FETCH_WAIT;
                    end else if (timeout_hit) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd3;
                    end
                end
                FETCH_WAIT: begin
                    if (ifu_resp_valid_i) begin
                        if (ifu_resp_err_i) begin
                            state_q     <= HALT;
                            halt_code_q <= 2'd2;
                        end else begin
                            state_q <= DECODE;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd3;
                    end
                end
                DECODE: begin
                    if (is_illegal_i) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd1;
                    end else if (is_ebreak_i) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd0;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= (is_load_i || is_store_i) ? MEM_REQ : WB;
                end
                MEM_REQ: begin
                    if (lsu_req_ready_i) begin
                        state_q <= MEM_WAIT;
                    end else if (timeout_hit) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd3;
                    end
                end
                MEM_WAIT: begin
                    if (lsu_resp_valid_i) begin
                        if (lsu_resp_err_i) begin
                            state_q     <= HALT;
                            halt_code_q <= 2'd2;
                        end else begin
                            state_q <= WB;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= HALT;
                        halt_code_q <= 2'd3;
                    end
                end
                WB: begin
                    instret_q <= instret_q + 64'd1;
                    state_q   <= FETCH_REQ;
                end
                HALT: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    // Strobes decode directly from the state register so they can never leak into other states.
    assign ifu_req_valid_o = (state_q == FETCH_REQ);
    assign lsu_req_valid_o = (state_q == MEM_REQ);
    assign inst_latch_o    = (state_q == FETCH_WAIT) && ifu_resp_valid_i && !ifu_resp_err_i;
    assign pc_wen_o        = (state_q == WB);
    assign rf_wen_o        = (state_q == WB) && rd_wen_i;
    assign halt_o          = (state_q == HALT);
    assign halt_code_o     = halt_code_q;
    assign instret_o       = instret_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - randomized self-checking bench for core_seq_ctrl
// Timeout cases run only when CORE_SEQ_TIMEOUT_EN is defined.
module tb_core_seq_ctrl;

    localparam logic [2:0] S_FREQ  = 3'd0;
    localparam logic [2:0] S_FWAIT = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_MREQ  = 3'd4;
    localparam logic [2:0] S_MWAIT = 3'd5;
    localparam logic [2:0] S_WB    = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ifu_req_valid_o;
    logic        ifu_req_ready_i;
    logic        ifu_resp_valid_i;
    logic        ifu_resp_err_i;
    logic        inst_latch_o;
    logic        is_load_i;
    logic        is_store_i;
    logic        is_ebreak_i;
    logic        is_illegal_i;
    logic        rd_wen_i;
    logic        lsu_req_valid_o;
    logic        lsu_req_ready_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic        rf_wen_o;
    logic        pc_wen_o;
    logic        halt_o;
    logic [1:0]  halt_code_o;
    logic [63:0] instret_o;
    logic [2:0]  state_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_ret;
    logic [1:0]  exp_code;
    logic        late_rsp = 1'b0;

    core_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ifu_req_valid_o  (ifu_req_valid_o),
        .ifu_req_ready_i  (ifu_req_ready_i),
        .ifu_resp_valid_i (ifu_resp_valid_i),
        .ifu_resp_err_i   (ifu_resp_err_i),
        .inst_latch_o     (inst_latch_o),
        .is_load_i        (is_load_i),
        .is_store_i       (is_store_i),
        .is_ebreak_i      (is_ebreak_i),
        .is_illegal_i     (is_illegal_i),
        .rd_wen_i         (rd_wen_i),
        .lsu_req_valid_o  (lsu_req_valid_o),
        .lsu_req_ready_i  (lsu_req_ready_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_err_i   (lsu_resp_err_i),
        .rf_wen_o         (rf_wen_o),
        .pc_wen_o         (pc_wen_o),
        .halt_o           (halt_o),
        .halt_code_o      (halt_code_o),
        .instret_o        (instret_o),
        .state_o          (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks outputs, returns at the next falling edge.
    // Inputs not sampled by the expected state get random noise.
    task automatic step(input logic [2:0] st, input logic ifr, input logic ifv, input logic ife,
                        input logic lr, input logic lv, input logic le, input logic latch);
        ifu_req_ready_i  = (st == S_FREQ)  ? ifr : 1'($urandom);
        ifu_resp_valid_i = (st == S_FWAIT) ? ifv : 1'($urandom);
        ifu_resp_err_i   = (st == S_FWAIT && ifv) ? ife : 1'($urandom);
        lsu_req_ready_i  = (st == S_MREQ)  ? lr : 1'($urandom);
        lsu_resp_valid_i = late_rsp ? 1'b1 : ((st == S_MWAIT) ? lv : 1'($urandom));
        lsu_resp_err_i   = (st == S_MWAIT && lv) ? le : 1'($urandom);
        #1;
        check_eq("state",         state_o,         st);
        check_eq("ifu_req_valid", ifu_req_valid_o, st == S_FREQ);
        check_eq("lsu_req_valid", lsu_req_valid_o, st == S_MREQ);
        check_eq("inst_latch",    inst_latch_o,    latch);
        check_eq("pc_wen",        pc_wen_o,        st == S_WB);
        check_eq("rf_wen",        rf_wen_o,        (st == S_WB) && rd_wen_i);
        check_eq("halt",          halt_o,          st == S_HALT);
        check_eq("halt_code",     halt_code_o,     exp_code);
        check_eq("instret",       instret_o,       exp_ret);
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        #1;
        exp_ret  = 64'd0;
        exp_code = 2'd0;
        check_eq("rst_state",     state_o,         S_FREQ);
        check_eq("rst_ifu_valid", ifu_req_valid_o, 1'b1);
        check_eq("rst_instret",   instret_o,       exp_ret);
        check_eq("rst_halt",      halt_o,          1'b0);
        check_eq("rst_halt_code", halt_code_o,     exp_code);
        check_eq("rst_pc_wen",    pc_wen_o,        1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // kind: 0 ALU, 1 load, 2 store. fd/md: stall cycles before ready; fr/mr: response latency after handshake (>=1).
    task automatic do_insn(input int kind, input logic rdw, input logic ill, input logic ebk,
                           input int fd, input int fr, input int md, input int mr,
                           input logic ferr, input logic merr, output logic halted);
        halted       = 1'b0;
        is_load_i    = (kind == 1);
        is_store_i   = (kind == 2);
        is_illegal_i = ill;
        is_ebreak_i  = ebk;
        rd_wen_i     = rdw && (kind != 2);
        for (int j = 0; j <= fd; j++) step(S_FREQ, j == fd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= fr; j++) step(S_FWAIT, 1'b0, j == fr, ferr, 1'b0, 1'b0, 1'b0, (j == fr) && !ferr);
        if (ferr) begin
            exp_code = 2'd2;
            halted   = 1'b1;
            return;
        end
        step(S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ill || ebk) begin
            exp_code = ill ? 2'd1 : 2'd0;
            halted   = 1'b1;
            return;
        end
        step(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (kind != 0) begin
            for (int j = 0; j <= md; j++) step(S_MREQ, 1'b0, 1'b0, 1'b0, j == md, 1'b0, 1'b0, 1'b0);
            for (int j = 1; j <= mr; j++) step(S_MWAIT, 1'b0, 1'b0, 1'b0, 1'b0, j == mr, merr, 1'b0);
            if (merr) begin
                exp_code = 2'd2;
                halted   = 1'b1;
                return;
            end
        end
        step(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 64'd1;
    endtask

    task automatic do_halt(input int n);
        for (int j = 0; j < n; j++) step(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic h;
        int   kind;
        rst_ni           = 1'b0;
        ifu_req_ready_i  = 1'b0;
        ifu_resp_valid_i = 1'b0;
        ifu_resp_err_i   = 1'b0;
        lsu_req_ready_i  = 1'b0;
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
        is_load_i        = 1'b0;
        is_store_i       = 1'b0;
        is_ebreak_i      = 1'b0;
        is_illegal_i     = 1'b0;
        rd_wen_i         = 1'b0;
        exp_ret          = 64'd0;
        exp_code         = 2'd0;
        @(negedge clk_i);
        apply_reset();

        // ALU, store with slow LSU, ALU, then ebreak after three retirements
        do_insn(0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1'b0, 1'b0, h);
        do_insn(2, 1'b1, 1'b0, 1'b0, 0, 1, 3, 2, 1'b0, 1'b0, h);
        do_insn(0, 1'b0, 1'b0, 1'b0, 1, 2, 0, 1, 1'b0, 1'b0, h);
        do_insn(0, 1'b1, 1'b0, 1'b1, 0, 1, 0, 1, 1'b0, 1'b0, h);
        check_eq("ebreak_halted", h, 1'b1);
        do_halt(100);

        // illegal beats ebreak
        apply_reset();
        do_insn(0, 1'b1, 1'b1, 1'b1, 0, 1, 0, 1, 1'b0, 1'b0, h);
        do_halt(10);

        // load bus error
        apply_reset();
        do_insn(1, 1'b1, 1'b0, 1'b0, 1, 1, 1, 2, 1'b0, 1'b1, h);
        do_halt(10);

        // fetch bus error
        apply_reset();
        do_insn(0, 1'b1, 1'b0, 1'b0, 0, 3, 0, 1, 1'b1, 1'b0, h);
        do_halt(10);

`ifdef CORE_SEQ_TIMEOUT_EN
        apply_reset();
        for (int j = 0; j < 16; j++) step(S_FREQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_code = 2'd3;
        do_halt(10);
        apply_reset();
        do_insn(1, 1'b1, 1'b0, 1'b0, 15, 16, 15, 16, 1'b0, 1'b0, h);
        check_eq("tmo_edge_retire", instret_o, 64'd1);
`endif

        // reset in the middle of MEM_WAIT, then a late response
        apply_reset();
        do_insn(0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1'b0, 1'b0, h);
        is_load_i    = 1'b1;
        is_store_i   = 1'b0;
        is_illegal_i = 1'b0;
        is_ebreak_i  = 1'b0;
        rd_wen_i     = 1'b1;
        step(S_FREQ,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(S_FWAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(S_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(S_EXEC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(S_MREQ,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(S_MWAIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        apply_reset();
        late_rsp = 1'b1;
        step(S_FREQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        late_rsp = 1'b0;
        do_insn(1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1'b0, 1'b0, h);
        check_eq("post_rst_retire", instret_o, 64'd1);

        // randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 2));
            do_insn(kind, 1'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                    ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0), h);
            if (h) begin
                do_halt(6);
                apply_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
